mipi_csi_rx_raw_depacker_16b2lane: RTL

//  Downstream stage of the 16b/2-lane CSI-2 packet decoder. Takes the stripped
//  32-bit payload (4 bytes/clk) plus the decoder's 3-bit packet type, and

---
 rtl/mipi_csi_rx_raw_depacker_16b2lane_pkg.sv | 43 ++++
 rtl/mipi_csi_rx_raw_depacker_16b2lane_if.sv | 24 ++
 rtl/mipi_csi_rx_raw_depacker_16b2lane_group_unpack.sv | 47 ++++
 rtl/mipi_csi_rx_raw_depacker_16b2lane.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane_pkg.sv
// Shared CSI-2 RAW packet-type codes, group sizes and FSM state encoding
// for the 16b/2-lane receive path.
package mipi_csi_rx_raw_depacker_16b2lane_pkg;

    typedef enum logic [2:0] {
        RAW10 = 3'h3,
        RAW12 = 3'h4,
        RAW14 = 3'h5
    } raw_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } state_e;

    localparam int unsigned GRP_MAX = 7;

    function automatic logic is_raw(input logic [2:0] t);
        case (t)
            RAW10, RAW12, RAW14: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] group_size(input logic [2:0] t);
        case (t)
            RAW10:   return 3'd5;
            RAW12:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [3:0] depth_of(input logic [2:0] t);
        case (t)
            RAW10:   return 4'd10;
            RAW12:   return 4'd12;
            RAW14:   return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane_if.sv
// Payload-in / pixel-out bundle between packet decoder, depacker and line buffer.
interface mipi_csi_rx_raw_depacker_16b2lane_if #(
    parameter int unsigned PIX_W   = 16,
    parameter int unsigned PIX_PER = 4
);
    logic                       data_valid_i;
    logic [31:0]                data_i;
    logic [2:0]                 packet_type_i;
    logic                       pixel_valid_o;
    logic [PIX_PER*PIX_W-1:0]   pixel_o;
    logic [3:0]                 bit_depth_o;
    logic                       line_end_o;
    logic                       residue_err_o;

    modport master (
        output data_valid_i, data_i, packet_type_i,
        input  pixel_valid_o, pixel_o, bit_depth_o, line_end_o, residue_err_o
    );

    modport slave (
        input  data_valid_i, data_i, packet_type_i,
        output pixel_valid_o, pixel_o, bit_depth_o, line_end_o, residue_err_o
    );
endinterface

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane_group_unpack.sv
// Combinational unpack of one RAW10/12/14 byte group (up to 7 bytes, byte 0
// oldest) into 4 right-justified, zero-extended pixels.
module mipi_csi_rx_raw_group_unpack
    import mipi_csi_rx_raw_depacker_16b2lane_pkg::*;
#(
    parameter int unsigned PIX_W = 16
) (
    input  logic [2:0]           packet_type,
    input  logic [8*GRP_MAX-1:0] group_bytes,
    output logic [4*PIX_W-1:0]   pixels
);
    logic [7:0]  b [GRP_MAX];
    logic [13:0] p [4];

    always_comb begin
        for (int unsigned i = 0; i < GRP_MAX; i++) begin
            b[i] = group_bytes[8*i +: 8];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            p[i] = '0;
        end
        case (packet_type)
            RAW10: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    p[i] = {4'b0, b[i], b[4][2*i +: 2]};
                end
            end
            RAW12: begin
                p[0] = {2'b0, b[0], b[2][3:0]};
                p[1] = {2'b0, b[1], b[2][7:4]};
                p[2] = {2'b0, b[3], b[5][3:0]};
                p[3] = {2'b0, b[4], b[5][7:4]};
            end
            RAW14: begin
                p[0] = {b[0], b[4][5:0]};
                p[1] = {b[1], b[5][3:0], b[4][7:6]};
                p[2] = {b[2], b[6][1:0], b[5][7:4]};
                p[3] = {b[3], b[6][7:2]};
            end
            default: ;
        endcase
        pixels = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            pixels[PIX_W*i +: PIX_W] = PIX_W'(p[i]);
        end
    end
endmodule

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane.sv
// RAW10/12/14 depacker: accumulates 4 payload bytes per clock and emits one
// registered beat of 4 pixels whenever a full byte group is available.
module mipi_csi_rx_raw_depacker_16b2lane
    import mipi_csi_rx_raw_depacker_16b2lane_pkg::*;
#(
    parameter int unsigned PIX_W     = 16,
    parameter int unsigned PIX_PER   = 4,
    parameter int unsigned BUF_BYTES = 12
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    mipi_csi_rx_raw_depacker_16b2lane_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(BUF_BYTES + 1);
    localparam int unsigned SW    = CNT_W + 1;

    state_e                   state_q, state_d;
    raw_type_e                type_q, type_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, g;
    logic [7:0]               buf_q [BUF_BYTES];
    logic [7:0]               buf_d [BUF_BYTES];
    logic [7:0]               stage [BUF_BYTES];
    logic [7:0]               shifted [BUF_BYTES];
    logic [2:0]               cur_type;
    logic [8*GRP_MAX-1:0]     grp;
    logic [PIX_PER*PIX_W-1:0] unpacked, pix_d;
    logic                     pix_valid_d, line_end_d, res_d, take;
    logic [3:0]               depth_d;

    // In IDLE the first beat is consumed in the same cycle the type is latched,
    // so the datapath looks at the live type there and the latched one after.
    always_comb begin
        cur_type = (state_q == ST_IDLE) ? bus.packet_type_i : type_q;
        g        = CNT_W'(group_size(cur_type));
        for (int unsigned j = 0; j < BUF_BYTES; j++) begin
            stage[j] = buf_q[j];
            for (int unsigned k = 0; k < 4; k++) begin
                if (SW'(j) == SW'(cnt_q) + SW'(k)) stage[j] = bus.data_i[8*k +: 8];
            end
        end
        for (int unsigned j = 0; j < BUF_BYTES; j++) begin
            shifted[j] = '0;
            for (int unsigned k = 0; k < BUF_BYTES; k++) begin
                if (SW'(k) == SW'(j) + SW'(g)) shifted[j] = stage[k];
            end
        end
        for (int unsigned i = 0; i < GRP_MAX; i++) begin
            grp[8*i +: 8] = stage[i];
        end
    end

    mipi_csi_rx_raw_group_unpack #(.PIX_W(PIX_W)) u_unpack (
        .packet_type (cur_type),
        .group_bytes (grp),
        .pixels      (unpacked)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        pix_valid_d = 1'b0;
        pix_d       = '0;
        depth_d     = bus.bit_depth_o;
        line_end_d  = 1'b0;
        res_d       = 1'b0;
        take        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                depth_d = '0;
                if (bus.data_valid_i) begin
                    if (is_raw(bus.packet_type_i)) begin
                        state_d = ST_ACTIVE;
                        type_d  = raw_type_e'(bus.packet_type_i);
                        depth_d = depth_of(bus.packet_type_i);
                        take    = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (bus.data_valid_i) begin
                    take = 1'b1;
                end else begin
                    line_end_d = 1'b1;
                    res_d      = (cnt_q != '0);
                    cnt_d      = '0;
                    buf_d      = '{default: '0};
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!bus.data_valid_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            if (SW'(cnt_q) + SW'(4) >= SW'(g)) begin
                pix_valid_d = 1'b1;
                pix_d       = unpacked;
                cnt_d       = cnt_q + CNT_W'(4) - g;
                buf_d       = shifted;
            end else begin
                cnt_d = cnt_q + CNT_W'(4);
                buf_d = stage;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q           <= ST_IDLE;
            type_q            <= RAW10;
            cnt_q             <= '0;
            buf_q             <= '{default: '0};
            bus.pixel_valid_o <= 1'b0;
            bus.pixel_o       <= '0;
            bus.bit_depth_o   <= '0;
            bus.line_end_o    <= 1'b0;
            bus.residue_err_o <= 1'b0;
        end else begin
            state_q           <= state_d;
            type_q            <= type_d;
            cnt_q             <= cnt_d;
            buf_q             <= buf_d;
            bus.pixel_valid_o <= pix_valid_d;
            bus.pixel_o       <= pix_d;
            bus.bit_depth_o   <= depth_d;
            bus.line_end_o    <= line_end_d;
            bus.residue_err_o <= res_d;
        end
    end
endmodule
